fft_mag_wr: RTL and testbench



---
 rtl/fft_mag_wr_pkg.sv | 42 ++++
 rtl/fft_mag_wr_if.sv | 28 ++
 rtl/fft_mag_wr_amax_bmin_mag.sv | 92 +++++++++
 rtl/fft_mag_wr.sv | 122 ++++++++++++
 tb/tb_fft_mag_wr.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_mag_wr_pkg.sv
// Shared types, sizes and helpers for the FFT magnitude writer.
// Holds the FSM state encoding, frame/bin sizing, the pipeline sideband
// payload and the saturating absolute-value helper.
package fft_mag_wr_pkg;

    localparam int unsigned FFT_LEN = 4096;
    localparam int unsigned BIN_W   = $clog2(FFT_LEN);
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned MAG_W   = 16;
    // Must stay >= analyser top search address + 3x peak bin.
    localparam int unsigned WR_BINS = 2048;
    localparam int unsigned DC_BINS = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_SOF = 3'd1,
        ST_CAPTURE  = 3'd2,
        ST_FLUSH    = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    // Sideband travelling alongside each beat through the magnitude pipeline.
    typedef struct packed {
        logic [BIN_W-1:0] bin;
        logic             wr_ok;   // bin < WR_BINS
        logic             dc;      // bin < DC_BINS, forced to zero
    } mag_side_t;

    // |x| with the most negative code saturated to the largest positive code.
    function automatic logic [DATA_W-1:0] abs_sat(input logic signed [DATA_W-1:0] x);
        logic [DATA_W-1:0] r;
        if (x == $signed({1'b1, {(DATA_W-1){1'b0}}})) begin
            r = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (x[DATA_W-1]) begin
            r = $unsigned(-x);
        end else begin
            r = $unsigned(x);
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_mag_wr_if.sv
// Stream and RAM-write interfaces for the FFT magnitude writer.
// fft_mag_wr_if: complex FFT beat stream (re, im, valid, last / ready).
// mag_wr_if    : single write port of the magnitude RAM (en, addr, data).
interface fft_mag_wr_if;
    import fft_mag_wr_pkg::*;

    logic signed [DATA_W-1:0] fft_re;
    logic signed [DATA_W-1:0] fft_im;
    logic                     fft_valid;
    logic                     fft_last;
    logic                     fft_ready;

    modport master (output fft_re, output fft_im, output fft_valid, output fft_last,
                    input  fft_ready);
    modport slave  (input  fft_re, input  fft_im, input  fft_valid, input  fft_last,
                    output fft_ready);
endinterface

interface mag_wr_if;
    import fft_mag_wr_pkg::*;

    logic             wr_en;
    logic [BIN_W-1:0] wr_addr;
    logic [MAG_W-1:0] wr_data;

    modport master (output wr_en, output wr_addr, output wr_data);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/fft_mag_wr_amax_bmin_mag.sv
// Three-stage alpha-max-beta-min magnitude pipeline.
// S1: abs of re/im, S2: max/min, S3: mx + mn/4 + mn/8 saturated, registered
// straight onto the RAM write port. Valid and sideband ride along; data
// registers only load on valid beats so bubbles never disturb held values.
// Ports: clk, rst_n, in_valid/in_re/in_im/in_side (accepted beat),
//        out_wr/out_addr/out_mag (RAM write strobe, address, magnitude).
module amax_bmin_mag
    import fft_mag_wr_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_re,
    input  logic signed [DATA_W-1:0] in_im,
    input  mag_side_t                in_side,
    output logic                     out_wr,
    output logic [BIN_W-1:0]         out_addr,
    output logic [MAG_W-1:0]         out_mag
);

    logic              s1_valid;
    logic [DATA_W-1:0] s1_a;
    logic [DATA_W-1:0] s1_b;
    mag_side_t         s1_side;

    logic              s2_valid;
    logic [DATA_W-1:0] s2_mx;
    logic [DATA_W-1:0] s2_mn;
    mag_side_t         s2_side;

    logic [MAG_W:0]    sum_c;
    logic [MAG_W-1:0]  mag_c;

    // S1: absolute values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_side  <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a    <= abs_sat(in_re);
                s1_b    <= abs_sat(in_im);
                s1_side <= in_side;
            end
        end
    end

    // S2: ordering
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_mx    <= '0;
            s2_mn    <= '0;
            s2_side  <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_mx   <= (s1_a >= s1_b) ? s1_a : s1_b;
                s2_mn   <= (s1_a >= s1_b) ? s1_b : s1_a;
                s2_side <= s1_side;
            end
        end
    end

    // S3 arithmetic: one extra bit catches overflow for saturation
    always_comb begin
        sum_c = (MAG_W+1)'(s2_mx) + (MAG_W+1)'(s2_mn >> 2) + (MAG_W+1)'(s2_mn >> 3);
        mag_c = sum_c[MAG_W] ? {MAG_W{1'b1}} : sum_c[MAG_W-1:0];
        if (s2_side.dc) begin
            mag_c = '0;
        end
    end

    // S3 register: RAM write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_wr   <= 1'b0;
            out_addr <= '0;
            out_mag  <= '0;
        end else begin
            out_wr <= s2_valid && s2_side.wr_ok;
            if (s2_valid) begin
                out_addr <= s2_side.bin;
                out_mag  <= mag_c;
            end
        end
    end

endmodule

// File: rtl/fft_mag_wr.sv
// FFT magnitude writer: captures one complex FFT frame per start, writes
// approximate magnitudes of the lower bins to the magnitude RAM and raises
// mag_done once the whole frame has been written.
// Ports: clk, rst_n, start (arm pulse), fft (beat stream, slave),
//        wr (RAM write port, master), mag_done (level, held until next start),
//        busy (WAIT_SOF/CAPTURE/FLUSH), frame_err (sticky length error).
module fft_mag_wr
    import fft_mag_wr_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    fft_mag_wr_if.slave    fft,
    mag_wr_if.master       wr,
    output logic           mag_done,
    output logic           busy,
    output logic           frame_err
);

    state_e           state_q;
    state_e           state_d;
    logic [BIN_W-1:0] bin_q;
    logic [BIN_W-1:0] bin_d;
    logic             flush_q;
    logic             flush_d;
    logic             err_d;
    logic             ready_q;
    logic             accept_c;
    mag_side_t        side_c;

    assign fft.fft_ready = ready_q;
    assign accept_c      = fft.fft_valid && ready_q;

    // Sideband for the beat being accepted this cycle
    always_comb begin
        side_c.bin   = bin_q;
        side_c.wr_ok = 32'(bin_q) < WR_BINS;
        side_c.dc    = 32'(bin_q) < DC_BINS;
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bin_q     <= '0;
            flush_q   <= 1'b0;
            ready_q   <= 1'b0;
            busy      <= 1'b0;
            mag_done  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            flush_q   <= flush_d;
            ready_q   <= (state_d == ST_WAIT_SOF) || (state_d == ST_CAPTURE);
            busy      <= (state_d == ST_WAIT_SOF) || (state_d == ST_CAPTURE) ||
                         (state_d == ST_FLUSH);
            mag_done  <= (state_d == ST_DONE);
            frame_err <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        flush_d = 1'b0;
        err_d   = frame_err;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_WAIT_SOF;
                    bin_d   = '0;
                    err_d   = 1'b0;
                end
            end
            ST_WAIT_SOF, ST_CAPTURE: begin
                // bin_q is always 0 in WAIT_SOF, so both states share the beat logic
                if (accept_c) begin
                    if (bin_q == BIN_W'(FFT_LEN - 1)) begin
                        state_d = ST_FLUSH;
                        bin_d   = '0;
                        if (!fft.fft_last) begin
                            err_d = 1'b1;
                        end
                    end else if (fft.fft_last) begin
                        // short frame: drop it, in-flight writes still complete
                        state_d = ST_WAIT_SOF;
                        bin_d   = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_CAPTURE;
                        bin_d   = bin_q + BIN_W'(1);
                    end
                end
            end
            ST_FLUSH: begin
                // two FLUSH cycles: mag_done rises with the final RAM write
                flush_d = 1'b1;
                if (flush_q) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    amax_bmin_mag u_mag (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (accept_c),
        .in_re    (fft.fft_re),
        .in_im    (fft.fft_im),
        .in_side  (side_c),
        .out_wr   (wr.wr_en),
        .out_addr (wr.wr_addr),
        .out_mag  (wr.wr_data)
    );

endmodule

// File: tb/tb_fft_mag_wr.sv
// Scoreboard bench for fft_mag_wr: expected writes are queued at beat
// acceptance and matched (address, data, cycle) when wr_en fires.
module tb_fft_mag_wr;

    logic clk;
    logic rst_n;
    logic start;
    logic mag_done;
    logic busy;
    logic frame_err;

    fft_mag_wr_if fft_if ();
    mag_wr_if     wr_if ();

    fft_mag_wr dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .fft       (fft_if),
        .wr        (wr_if),
        .mag_done  (mag_done),
        .busy      (busy),
        .frame_err (frame_err)
    );

    typedef struct {
        int addr;
        int data;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   wr_cnt   = 0;
    int   max_addr = -1;
    int   done_rise = -1;
    int   last_acc = -1;
    int   mem[0:4095];
    bit   done_prev = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference magnitude, written from the algorithm description
    function automatic int exp_mag(input int bin, input int re, input int im);
        int a;
        int b;
        int mx;
        int mn;
        int s;
        if (bin < 2) return 0;
        a  = (re < 0) ? ((re == -32768) ? 32767 : -re) : re;
        b  = (im < 0) ? ((im == -32768) ? 32767 : -im) : im;
        mx = (a > b) ? a : b;
        mn = (a > b) ? b : a;
        s  = mx + (mn / 4) + (mn / 8);
        if (s > 65535) s = 65535;
        return s;
    endfunction

    // Write-port monitor: pops the scoreboard on every RAM write
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                done_prev = 0;
            end else begin
                if (wr_if.wr_en) begin
                    wr_cnt++;
                    mem[int'(wr_if.wr_addr)] = int'(wr_if.wr_data);
                    if (int'(wr_if.wr_addr) > max_addr) max_addr = int'(wr_if.wr_addr);
                    n_checks++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_write: got addr=%0d data=%0d, required no write",
                                 wr_if.wr_addr, wr_if.wr_data);
                    end else begin
                        e = sb.pop_front();
                        if (int'(wr_if.wr_addr) !== e.addr || int'(wr_if.wr_data) !== e.data ||
                            cyc !== e.cyc) begin
                            n_fail++;
                            $display("FAIL write_match: got addr=%0d data=%0d cyc=%0d, required addr=%0d data=%0d cyc=%0d",
                                     wr_if.wr_addr, wr_if.wr_data, cyc, e.addr, e.data, e.cyc);
                        end
                    end
                end
                if (mag_done && !done_prev) done_rise = cyc;
                done_prev = mag_done;
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Drive n_beats beats; mode 0 = single tone, mode 1 = math corners + random
    task automatic drive_frame(input int mode, input int n_beats, input int last_at,
                               input bit gaps, input bit start_pulses);
        int   i = 0;
        int   re;
        int   im;
        int   stall = 0;
        exp_t e;
        while (i < n_beats) begin
            @(negedge clk);
            start = 1'b0;
            if (gaps) begin
                fft_if.fft_valid = 1'b0;
                fft_if.fft_last  = 1'b0;
                @(negedge clk);
            end
            if (mode == 0) begin
                re = (i == 128) ? 1000 : 0;
                im = 0;
            end else if (i == 1) begin
                re = 5000;   im = 0;
            end else if (i == 2) begin
                re = -400;   im = 300;
            end else if (i == 3) begin
                re = -32768; im = -32768;
            end else begin
                re = int'($urandom_range(0, 65535)) - 32768;
                im = int'($urandom_range(0, 65535)) - 32768;
            end
            fft_if.fft_re    = 16'(re);
            fft_if.fft_im    = 16'(im);
            fft_if.fft_valid = 1'b1;
            fft_if.fft_last  = (i == last_at);
            if (start_pulses && (i % 1000 == 500)) start = 1'b1;
            if (fft_if.fft_ready) begin
                if (i < 2048) begin
                    e.addr = i;
                    e.data = exp_mag(i, re, im);
                    e.cyc  = cyc + 3;
                    sb.push_back(e);
                end
                last_acc = cyc;
                i++;
                stall = 0;
            end else begin
                stall++;
                if (stall > 50) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL ready_timeout: got fft_ready=0 at beat %0d, required 1", i);
                    break;
                end
            end
        end
        @(negedge clk);
        start            = 1'b0;
        fft_if.fft_valid = 1'b0;
        fft_if.fft_last  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!mag_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (!mag_done) begin
            n_fail++;
            $display("FAIL done_timeout: got mag_done=0 after %0d cycles, required 1", budget);
        end
    endtask

    task automatic check_frame_done(input string name);
        n_checks++;
        if (done_rise !== last_acc + 3) begin
            n_fail++;
            $display("FAIL %s_done_latency: got rise cyc=%0d, required %0d", name, done_rise, last_acc + 3);
        end
        n_checks++;
        if (wr_cnt !== 2048) begin
            n_fail++;
            $display("FAIL %s_write_count: got %0d, required 2048", name, wr_cnt);
        end
        n_checks++;
        if (max_addr >= 2048) begin
            n_fail++;
            $display("FAIL %s_max_addr: got %0d, required < 2048", name, max_addr);
        end
        n_checks++;
        if (sb.size() !== 0) begin
            n_fail++;
            $display("FAIL %s_sb_empty: got %0d pending, required 0", name, sb.size());
        end
    endtask

    task automatic clear_frame_stats();
        wr_cnt    = 0;
        max_addr  = -1;
        done_rise = -1;
        for (int k = 0; k < 4096; k++) mem[k] = -1;
    endtask

    task automatic test_reset();
        rst_n            = 1'b0;
        start            = 1'b0;
        fft_if.fft_re    = '0;
        fft_if.fft_im    = '0;
        fft_if.fft_valid = 1'b0;
        fft_if.fft_last  = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({fft_if.fft_ready, wr_if.wr_en, wr_if.wr_addr, wr_if.wr_data, mag_done, busy, frame_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ready=%b wr_en=%b addr=%0d data=%0d done=%b busy=%b err=%b, required all 0",
                     fft_if.fft_ready, wr_if.wr_en, wr_if.wr_addr, wr_if.wr_data, mag_done, busy, frame_err);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (fft_if.fft_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got ready=%b busy=%b, required 0 0", fft_if.fft_ready, busy);
        end
    endtask

    task automatic test_tone();
        clear_frame_stats();
        pulse_start();
        drive_frame(0, 4096, 4095, 1'b0, 1'b0);
        wait_done(20);
        check_frame_done("tone");
        n_checks++;
        if (mem[128] !== 1000 || mem[127] !== 0 || mem[129] !== 0) begin
            n_fail++;
            $display("FAIL tone_bins: got [127]=%0d [128]=%0d [129]=%0d, required 0 1000 0",
                     mem[127], mem[128], mem[129]);
        end
        n_checks++;
        if (frame_err !== 1'b0 || busy !== 1'b0 || fft_if.fft_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL tone_status: got err=%b busy=%b ready=%b, required 0 0 0",
                     frame_err, busy, fft_if.fft_ready);
        end
    endtask

    task automatic test_rearm();
        pulse_start();
        n_checks++;
        if (mag_done !== 1'b0 || fft_if.fft_ready !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rearm: got done=%b ready=%b busy=%b, required 0 1 1",
                     mag_done, fft_if.fft_ready, busy);
        end
    endtask

    // Also pulses start during CAPTURE; the scoreboard checks bins are unaffected
    task automatic test_math();
        clear_frame_stats();
        drive_frame(1, 4096, 4095, 1'b0, 1'b1);
        wait_done(20);
        check_frame_done("math");
        n_checks++;
        if (mem[1] !== 0 || mem[2] !== 512 || mem[3] !== 45053) begin
            n_fail++;
            $display("FAIL math_values: got [1]=%0d [2]=%0d [3]=%0d, required 0 512 45053",
                     mem[1], mem[2], mem[3]);
        end
    endtask

    task automatic test_gaps();
        clear_frame_stats();
        pulse_start();
        drive_frame(1, 4096, 4095, 1'b1, 1'b0);
        wait_done(20);
        check_frame_done("gaps");
    endtask

    task automatic test_short();
        pulse_start();
        drive_frame(0, 100, 99, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        n_checks++;
        if (frame_err !== 1'b1 || mag_done !== 1'b0 || fft_if.fft_ready !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL short_status: got err=%b done=%b ready=%b busy=%b, required 1 0 1 1",
                     frame_err, mag_done, fft_if.fft_ready, busy);
        end
        clear_frame_stats();
        drive_frame(0, 4096, 4095, 1'b0, 1'b0);
        wait_done(20);
        check_frame_done("after_short");
        n_checks++;
        if (frame_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: got frame_err=%b, required 1", frame_err);
        end
        pulse_start();
        n_checks++;
        if (frame_err !== 1'b0 || mag_done !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear: got err=%b done=%b, required 0 0", frame_err, mag_done);
        end
    endtask

    task automatic test_reset_mid();
        int wc;
        drive_frame(0, 1000, -1, 1'b0, 1'b0);
        @(negedge clk);
        fft_if.fft_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({fft_if.fft_ready, wr_if.wr_en, wr_if.wr_addr, wr_if.wr_data, mag_done, busy, frame_err} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got ready=%b wr_en=%b addr=%0d data=%0d done=%b busy=%b err=%b, required all 0",
                     fft_if.fft_ready, wr_if.wr_en, wr_if.wr_addr, wr_if.wr_data, mag_done, busy, frame_err);
        end
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wc = wr_cnt;
        repeat (20) @(negedge clk);
        n_checks++;
        if (wr_cnt !== wc || fft_if.fft_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got writes=%0d ready=%b busy=%b, required 0 0 0",
                     wr_cnt - wc, fft_if.fft_ready, busy);
        end
        fft_if.fft_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_tone();
        test_rearm();
        test_math();
        test_gaps();
        test_short();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
